// File: rtl/bomb_pkg.sv
// Shared types and constants for the BCD countdown timer.
// Holds the state encoding, the BCD nine digit and the digit-count limit.
package bomb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_EXPIRED = 2'd2,
    ST_DEFUSED = 2'd3
  } state_t;

  localparam logic [3:0] BCD_NINE   = 4'd9;
  localparam int         MAX_DIGITS = 8;

  // Digits above nine are not valid BCD; treat them as nine.
  function automatic logic [3:0] clamp_digit(input logic [3:0] d);
    return (d > BCD_NINE) ? BCD_NINE : d;
  endfunction

endpackage

// File: rtl/bcd_countdown_timer_if.sv
// Control and status bundle of the countdown timer.
// The controller drives strobes/levels; the timer returns registered status.
interface bcd_countdown_timer_if #(
  parameter int DIGITS = 3
);
  // tick/start/strike/defuse/abort are one-cycle strobes and pause is a level,
  // all sampled at the rising clock edge. There is no ready: every strobe is consumed.
  logic                  tick;
  logic                  start;
  logic [4*DIGITS-1:0]   load_bcd;
  logic                  pause;
  logic                  strike;
  logic [4*DIGITS-1:0]   penalty_bcd;
  logic                  defuse;
  logic                  abort;
  logic [4*DIGITS-1:0]   digits_bcd;
  logic [1:0]            state;
  logic                  expire_pulse;

  modport master (
    output tick, start, load_bcd, pause, strike, penalty_bcd, defuse, abort,
    input  digits_bcd, state, expire_pulse
  );

  modport slave (
    input  tick, start, load_bcd, pause, strike, penalty_bcd, defuse, abort,
    output digits_bcd, state, expire_pulse
  );

endinterface

// File: rtl/bcd_countdown_timer_core.sv
// Countdown state machine: loads, decrements, applies strike penalties and
// reports expiry. All status outputs come straight from registers.
module bcd_countdown_timer_core
  import bomb_pkg::*;
#(
  parameter int DIGITS = 3
) (
  input logic                  clk,
  input logic                  reset,
  bcd_countdown_timer_if.slave bus
);

  localparam int W = 4 * DIGITS;
  localparam logic [W-1:0] ALL_NINES = {DIGITS{BCD_NINE}};

  state_t         state_q, state_d;
  logic [W-1:0]   digits_q, digits_d;
  logic           expire_q, expire_d;

  logic [W-1:0]   load_clamped;
  logic [W-1:0]   penalty_clamped;
  logic [W-1:0]   sub_b;
  logic [W-1:0]   sub_diff;
  logic           sub_zero;
  logic           tick_eff;
  logic           do_sub;
  logic           load_zero;

  always_comb begin
    load_clamped    = '0;
    penalty_clamped = '0;
    for (int i = 0; i < DIGITS; i++) begin
      load_clamped[4*i +: 4]    = clamp_digit(bus.load_bcd[4*i +: 4]);
      penalty_clamped[4*i +: 4] = clamp_digit(bus.penalty_bcd[4*i +: 4]);
    end
  end

  // A simultaneous strike and unpaused tick costs penalty+1 via the borrow input.
  assign tick_eff  = bus.tick & ~bus.pause;
  assign do_sub    = bus.strike | tick_eff;
  assign sub_b     = bus.strike ? penalty_clamped : '0;
  assign load_zero = (load_clamped == '0);

  bcd_sub_sat #(.DIGITS(DIGITS)) u_sub (
    .a         (digits_q),
    .b         (sub_b),
    .borrow_in (tick_eff),
    .diff      (sub_diff),
    .zero      (sub_zero)
  );

  always_comb begin
    state_d  = state_q;
    digits_d = digits_q;
    expire_d = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (bus.abort) begin
          state_d  = ST_IDLE;
          digits_d = ALL_NINES;
        end else if (bus.defuse) begin
          state_d  = ST_DEFUSED;
        end else if (do_sub) begin
          digits_d = sub_diff;
          if (sub_zero) begin
            state_d  = ST_EXPIRED;
            expire_d = 1'b1;
          end
        end
      end
      default: begin
        // IDLE, EXPIRED and DEFUSED only react to abort and start.
        if (bus.abort) begin
          state_d  = ST_IDLE;
          digits_d = ALL_NINES;
        end else if (bus.start) begin
          digits_d = load_clamped;
          if (load_zero) begin
            state_d  = ST_EXPIRED;
            expire_d = 1'b1;
          end else begin
            state_d  = ST_RUN;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      digits_q <= ALL_NINES;
      expire_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      digits_q <= digits_d;
      expire_q <= expire_d;
    end
  end

  assign bus.digits_bcd   = digits_q;
  assign bus.state        = state_q;
  assign bus.expire_pulse = expire_q;

endmodule

// File: rtl/bcd_sub_sat.sv
// Combinational DIGITS-wide BCD subtractor computing a - b - borrow_in,
// saturating at zero on underflow, with a zero flag on the result.
module bcd_sub_sat #(
  parameter int DIGITS = 3
) (
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  input  logic                borrow_in,
  output logic [4*DIGITS-1:0] diff,
  output logic                zero
);

  logic [4*DIGITS-1:0] raw;
  logic                underflow;

  always_comb begin
    logic [4:0] t;
    logic       borrow;
    raw    = '0;
    borrow = borrow_in;
    t      = '0;
    for (int i = 0; i < DIGITS; i++) begin
      t = {1'b0, a[4*i +: 4]} - {1'b0, b[4*i +: 4]} - {4'b0000, borrow};
      // A negative digit result wraps mod 32; adding ten yields the BCD digit.
      if (t[4]) begin
        t      = t + 5'd10;
        borrow = 1'b1;
      end else begin
        borrow = 1'b0;
      end
      raw[4*i +: 4] = t[3:0];
    end
    underflow = borrow;
  end

  assign diff = underflow ? '0 : raw;
  assign zero = (diff == '0);

endmodule

// File: rtl/bcd_countdown_timer.sv
// Top of the BCD countdown timer: flat pin-level ports bundled onto the
// control/status interface that feeds the timer core.
module bcd_countdown_timer
  import bomb_pkg::*;
#(
  parameter int DIGITS = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                tick,
  input  logic                start,
  input  logic [4*DIGITS-1:0] load_bcd,
  input  logic                pause,
  input  logic                strike,
  input  logic [4*DIGITS-1:0] penalty_bcd,
  input  logic                defuse,
  input  logic                abort,
  output logic [4*DIGITS-1:0] digits_bcd,
  output logic [1:0]          state_o,
  output logic                expire_pulse
);

  bcd_countdown_timer_if #(.DIGITS(DIGITS)) bus ();

  assign bus.tick        = tick;
  assign bus.start       = start;
  assign bus.load_bcd    = load_bcd;
  assign bus.pause       = pause;
  assign bus.strike      = strike;
  assign bus.penalty_bcd = penalty_bcd;
  assign bus.defuse      = defuse;
  assign bus.abort       = abort;

  bcd_countdown_timer_core #(.DIGITS(DIGITS)) u_core (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  assign digits_bcd   = bus.digits_bcd;
  assign state_o      = bus.state;
  assign expire_pulse = bus.expire_pulse;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Directed bench for bcd_countdown_timer with DIGITS=3: a vector table of
// single-cycle steps followed by hand-written multi-cycle sequences.
module tb_bcd_countdown_timer;

  localparam int DIGITS = 3;
  localparam int W = 4 * DIGITS;
  localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_EXP = 2'd2, S_DEF = 2'd3;

  logic clk;
  logic reset;

  bcd_countdown_timer_if #(.DIGITS(DIGITS)) bus ();

  bcd_countdown_timer #(.DIGITS(DIGITS)) dut (
    .clk          (clk),
    .reset        (reset),
    .tick         (bus.tick),
    .start        (bus.start),
    .load_bcd     (bus.load_bcd),
    .pause        (bus.pause),
    .strike       (bus.strike),
    .penalty_bcd  (bus.penalty_bcd),
    .defuse       (bus.defuse),
    .abort        (bus.abort),
    .digits_bcd   (bus.digits_bcd),
    .state_o      (bus.state),
    .expire_pulse (bus.expire_pulse)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       rst_n;
    logic       start;
    logic [W-1:0] load;
    logic       tick;
    logic       pause;
    logic       strike;
    logic [W-1:0] penalty;
    logic       defuse;
    logic       abort;
    logic [W-1:0] exp_d;
    logic [1:0] exp_s;
    logic       exp_p;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;

  function automatic vec_t mk(string name, logic rst_n, logic start, logic [W-1:0] load,
                              logic tick, logic pause, logic strike, logic [W-1:0] penalty,
                              logic defuse, logic abort,
                              logic [W-1:0] exp_d, logic [1:0] exp_s, logic exp_p);
    vec_t v;
    v.name = name; v.rst_n = rst_n; v.start = start; v.load = load;
    v.tick = tick; v.pause = pause; v.strike = strike; v.penalty = penalty;
    v.defuse = defuse; v.abort = abort;
    v.exp_d = exp_d; v.exp_s = exp_s; v.exp_p = exp_p;
    return v;
  endfunction

  // driver tasks
  task automatic drive(logic rst_n, logic start, logic [W-1:0] load, logic tick, logic pause,
                       logic strike, logic [W-1:0] penalty, logic defuse, logic abort);
    reset           = rst_n;
    bus.start       = start;
    bus.load_bcd    = load;
    bus.tick        = tick;
    bus.pause       = pause;
    bus.strike      = strike;
    bus.penalty_bcd = penalty;
    bus.defuse      = defuse;
    bus.abort       = abort;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // scoreboard comparison
  task automatic check(string name, logic [W-1:0] exp_d, logic [1:0] exp_s, logic exp_p);
    n_vec++;
    if (bus.digits_bcd !== exp_d || bus.state !== exp_s || bus.expire_pulse !== exp_p) begin
      n_err++;
      $display("FAIL %s: got digits=%03h state=%0d pulse=%b, expected digits=%03h state=%0d pulse=%b",
               name, bus.digits_bcd, bus.state, bus.expire_pulse, exp_d, exp_s, exp_p);
    end
  endtask

  // single-cycle helper: drive normal operation inputs, clock, compare
  task automatic cyc(string name, logic start, logic [W-1:0] load, logic tick, logic pause,
                     logic strike, logic [W-1:0] penalty, logic defuse, logic abort,
                     logic [W-1:0] exp_d, logic [1:0] exp_s, logic exp_p);
    drive(1'b1, start, load, tick, pause, strike, penalty, defuse, abort);
    step();
    check(name, exp_d, exp_s, exp_p);
  endtask

  vec_t vecs[$];

  initial begin
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);

    //           name           rst start load    tck pau str pen     def abt  exp_d   state   pulse
    vecs.push_back(mk("reset",        0, 0, 12'h000, 0, 0, 0, 12'h000, 0, 0, 12'h999, S_IDLE, 0));
    vecs.push_back(mk("reset_start",  0, 1, 12'h300, 1, 0, 0, 12'h000, 0, 0, 12'h999, S_IDLE, 0));
    vecs.push_back(mk("idle_hold",    1, 0, 12'h300, 1, 0, 1, 12'h001, 0, 0, 12'h999, S_IDLE, 0));
    vecs.push_back(mk("load_300",     1, 1, 12'h300, 0, 0, 0, 12'h000, 0, 0, 12'h300, S_RUN,  0));
    vecs.push_back(mk("tick_299",     1, 0, 12'h000, 1, 0, 0, 12'h000, 0, 0, 12'h299, S_RUN,  0));
    vecs.push_back(mk("tick_298",     1, 0, 12'h000, 1, 0, 0, 12'h000, 0, 0, 12'h298, S_RUN,  0));
    vecs.push_back(mk("start_in_run", 1, 1, 12'h555, 0, 0, 0, 12'h000, 0, 0, 12'h298, S_RUN,  0));
    vecs.push_back(mk("abort_run",    1, 0, 12'h000, 1, 0, 1, 12'h005, 1, 1, 12'h999, S_IDLE, 0));
    vecs.push_back(mk("load_100",     1, 1, 12'h100, 0, 0, 0, 12'h000, 0, 0, 12'h100, S_RUN,  0));
    vecs.push_back(mk("borrow_099",   1, 0, 12'h000, 1, 0, 0, 12'h000, 0, 0, 12'h099, S_RUN,  0));
    vecs.push_back(mk("abort_2",      1, 0, 12'h000, 0, 0, 0, 12'h000, 0, 1, 12'h999, S_IDLE, 0));
    vecs.push_back(mk("clamp_0f5",    1, 1, 12'h0F5, 0, 0, 0, 12'h000, 0, 0, 12'h095, S_RUN,  0));
    vecs.push_back(mk("tick_094",     1, 0, 12'h000, 1, 0, 0, 12'h000, 0, 0, 12'h094, S_RUN,  0));
    vecs.push_back(mk("abort_3",      1, 0, 12'h000, 0, 0, 0, 12'h000, 0, 1, 12'h999, S_IDLE, 0));
    vecs.push_back(mk("clamp_9a9",    1, 1, 12'h9A9, 0, 0, 0, 12'h000, 0, 0, 12'h999, S_RUN,  0));
    vecs.push_back(mk("tick_998",     1, 0, 12'h000, 1, 0, 0, 12'h000, 0, 0, 12'h998, S_RUN,  0));
    vecs.push_back(mk("abort_4",      1, 0, 12'h000, 0, 0, 0, 12'h000, 0, 1, 12'h999, S_IDLE, 0));
    vecs.push_back(mk("load_zero",    1, 1, 12'h000, 0, 0, 0, 12'h000, 0, 0, 12'h000, S_EXP,  1));
    vecs.push_back(mk("pulse_once",   1, 0, 12'h000, 0, 0, 0, 12'h000, 0, 0, 12'h000, S_EXP,  0));
    vecs.push_back(mk("reload_120",   1, 1, 12'h120, 0, 0, 0, 12'h030, 0, 0, 12'h120, S_RUN,  0));
    vecs.push_back(mk("strike_tick",  1, 0, 12'h000, 1, 0, 1, 12'h030, 0, 0, 12'h089, S_RUN,  0));
    vecs.push_back(mk("strike_200",   1, 0, 12'h000, 0, 0, 1, 12'h200, 0, 0, 12'h000, S_EXP,  1));
    vecs.push_back(mk("exp_hold",     1, 0, 12'h000, 0, 0, 0, 12'h000, 0, 0, 12'h000, S_EXP,  0));
    vecs.push_back(mk("exp_ignore",   1, 0, 12'h000, 1, 0, 1, 12'h100, 1, 0, 12'h000, S_EXP,  0));
    vecs.push_back(mk("reload_050",   1, 1, 12'h050, 0, 0, 0, 12'h000, 0, 0, 12'h050, S_RUN,  0));
    vecs.push_back(mk("pen_clamp",    1, 0, 12'h000, 1, 1, 1, 12'h0A0, 0, 0, 12'h000, S_EXP,  1));
    vecs.push_back(mk("exp_hold_2",   1, 0, 12'h000, 0, 0, 0, 12'h000, 0, 0, 12'h000, S_EXP,  0));
    vecs.push_back(mk("reload_050b",  1, 1, 12'h050, 0, 0, 0, 12'h000, 0, 0, 12'h050, S_RUN,  0));
    vecs.push_back(mk("strike_paused",1, 0, 12'h000, 1, 1, 1, 12'h012, 0, 0, 12'h038, S_RUN,  0));
    vecs.push_back(mk("defuse_tick",  1, 0, 12'h000, 1, 0, 0, 12'h000, 1, 0, 12'h038, S_DEF,  0));
    vecs.push_back(mk("def_ignore",   1, 0, 12'h000, 1, 0, 1, 12'h001, 1, 0, 12'h038, S_DEF,  0));
    vecs.push_back(mk("abort_start",  1, 1, 12'h123, 0, 0, 0, 12'h000, 0, 1, 12'h999, S_IDLE, 0));

    foreach (vecs[i]) begin
      drive(vecs[i].rst_n, vecs[i].start, vecs[i].load, vecs[i].tick, vecs[i].pause,
            vecs[i].strike, vecs[i].penalty, vecs[i].defuse, vecs[i].abort);
      step();
      check(vecs[i].name, vecs[i].exp_d, vecs[i].exp_s, vecs[i].exp_p);
    end

    // countdown 005 to expiry, pulse exactly once, then frozen
    cyc("load_005", 1, 12'h005, 0, 0, 0, 12'h000, 0, 0, 12'h005, S_RUN, 0);
    for (int k = 4; k >= 1; k--)
      cyc("count_005", 0, 12'h000, 1, 0, 0, 12'h000, 0, 0, W'(k), S_RUN, 0);
    cyc("expire_005", 0, 12'h000, 1, 0, 0, 12'h000, 0, 0, 12'h000, S_EXP, 1);
    cyc("pulse_drop", 0, 12'h000, 1, 0, 0, 12'h000, 0, 0, 12'h000, S_EXP, 0);
    for (int k = 0; k < 3; k++)
      cyc("exp_frozen", 0, 12'h000, 1, 0, 1, 12'h002, 0, 0, 12'h000, S_EXP, 0);

    // pause blocks ticks, then defuse, abort and reload
    cyc("load_300b", 1, 12'h300, 0, 0, 0, 12'h000, 0, 0, 12'h300, S_RUN, 0);
    for (int k = 0; k < 10; k++)
      cyc("paused", 0, 12'h000, 1, 1, 0, 12'h000, 0, 0, 12'h300, S_RUN, 0);
    cyc("defuse", 0, 12'h000, 0, 0, 0, 12'h000, 1, 0, 12'h300, S_DEF, 0);
    cyc("def_frozen", 0, 12'h000, 1, 0, 0, 12'h000, 0, 0, 12'h300, S_DEF, 0);
    cyc("def_abort", 0, 12'h000, 0, 0, 0, 12'h000, 0, 1, 12'h999, S_IDLE, 0);
    cyc("reload_042", 1, 12'h042, 0, 0, 0, 12'h000, 0, 0, 12'h042, S_RUN, 0);

    // reset wins over a same-cycle expiry
    cyc("abort_5", 0, 12'h000, 0, 0, 0, 12'h000, 0, 1, 12'h999, S_IDLE, 0);
    cyc("load_002", 1, 12'h002, 0, 0, 0, 12'h000, 0, 0, 12'h002, S_RUN, 0);
    cyc("tick_001", 0, 12'h000, 1, 0, 0, 12'h000, 0, 0, 12'h001, S_RUN, 0);
    drive(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    step();
    check("reset_vs_expiry", 12'h999, S_IDLE, 0);
    for (int k = 0; k < 3; k++)
      cyc("no_late_pulse", 0, 12'h000, 0, 0, 0, 12'h000, 0, 0, 12'h999, S_IDLE, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
